// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared limits, packed time type and state encoding
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
  } time_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BROWSE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen : DIV-cycle divider, held at zero while disabled, one-cycle tick
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/lap_timer_core.sv
// ---------------------------------------------------------------------------
// lap_timer_core : stopwatch with lap buffer, browse mode and optional
//                  countdown (enabled by defining STOPWATCH_COUNTDOWN_EN)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lap_timer_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int DEPTH   = 6,
  parameter int MAX_MIN = 59
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start_stop,
  input  logic                       i_record,
  input  logic                       i_browse,
  input  logic                       i_clear,
  input  logic                       i_mode_down,
  input  logic [5:0]                 i_preset_min,
  input  logic [5:0]                 i_preset_sec,
  output logic [5:0]                 o_disp_min,
  output logic [5:0]                 o_disp_sec,
  output logic [6:0]                 o_disp_cs,
  output logic                       o_running,
  output logic                       o_browsing,
  output logic [$clog2(DEPTH)-1:0]   o_browse_idx,
  output logic [$clog2(DEPTH+1)-1:0] o_rec_count,
  output logic                       o_overflow,
  output logic                       o_expired
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = IW + 1;
  localparam logic [5:0] C_MAX_MIN = 6'(MAX_MIN);
  localparam logic [5:0] C_SEC_MAX = 6'(SEC_MAX);
  localparam logic [6:0] C_CS_MAX  = 7'(CS_MAX);

  state_t        r_state, w_state_nx;
  time_t         r_time, w_time_nx, w_time_inc, w_time_dec, r_disp;
  time_t         r_laps [DEPTH];
  logic [IW-1:0] r_wr_ptr, w_wr_ptr_nx, r_browse_idx, w_idx_nx, w_slot;
  logic [CW-1:0] r_rec_count, w_rec_nx;
  logic [SW-1:0] w_slot_sum;
  logic          r_overflow, w_ovf_nx, r_expired, w_exp_nx;
  logic          r_mode_down, w_mode_nx, w_mode_in;
  logic          w_tick, w_wrap, w_time_zero, w_store, w_cd_done;
  time_t         w_load;

`ifdef STOPWATCH_COUNTDOWN_EN
  // Presets beyond the display limits saturate on load.
  always_comb begin
    w_load     = '0;
    w_load.min = (i_preset_min > C_MAX_MIN) ? C_MAX_MIN : i_preset_min;
    w_load.sec = (i_preset_sec > C_SEC_MAX) ? C_SEC_MAX : i_preset_sec;
    w_mode_in  = i_mode_down;
  end
`else
  logic w_unused_cd;
  assign w_unused_cd = ^{i_mode_down, i_preset_min, i_preset_sec};
  assign w_load      = '0;
  assign w_mode_in   = 1'b0;
`endif

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_RUN),
    .o_tick (w_tick)
  );

  assign w_time_zero = (r_time == '0);

  always_comb begin
    w_time_inc = r_time;
    w_wrap     = 1'b0;
    if (r_time.cs != C_CS_MAX) begin
      w_time_inc.cs = r_time.cs + 7'd1;
    end else begin
      w_time_inc.cs = '0;
      if (r_time.sec != C_SEC_MAX) begin
        w_time_inc.sec = r_time.sec + 6'd1;
      end else begin
        w_time_inc.sec = '0;
        if (r_time.min != C_MAX_MIN) begin
          w_time_inc.min = r_time.min + 6'd1;
        end else begin
          w_time_inc.min = '0;
          w_wrap         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_time_dec = r_time;
    if (r_time.cs != 7'd0) begin
      w_time_dec.cs = r_time.cs - 7'd1;
    end else if (!w_time_zero) begin
      w_time_dec.cs = C_CS_MAX;
      if (r_time.sec != 6'd0) begin
        w_time_dec.sec = r_time.sec - 6'd1;
      end else begin
        w_time_dec.sec = C_SEC_MAX;
        w_time_dec.min = r_time.min - 6'd1;
      end
    end
  end

  // Only the highest-priority pulse (clear > browse > start_stop > record) is seen.
  always_comb begin
    w_state_nx  = r_state;
    w_time_nx   = r_time;
    w_wr_ptr_nx = r_wr_ptr;
    w_rec_nx    = r_rec_count;
    w_idx_nx    = r_browse_idx;
    w_ovf_nx    = r_overflow;
    w_exp_nx    = r_expired;
    w_mode_nx   = r_mode_down;
    w_store     = 1'b0;
    w_cd_done   = 1'b0;

    if ((r_state == ST_RUN) && w_tick) begin
      if (r_mode_down) begin
        w_time_nx = w_time_dec;
        if (w_time_dec == '0) begin
          w_exp_nx  = 1'b1;
          w_cd_done = 1'b1;
        end
      end else begin
        w_time_nx = w_time_inc;
        if (w_wrap) w_ovf_nx = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (i_clear) begin
          w_time_nx = w_mode_in ? w_load : '0;
          w_mode_nx = w_mode_in;
          w_ovf_nx  = 1'b0;
          w_exp_nx  = 1'b0;
        end else if (i_browse) begin
          if (r_rec_count != '0) begin
            w_state_nx = ST_BROWSE;
            w_idx_nx   = '0;
          end
        end else if (i_start_stop) begin
          if (!(r_mode_down && w_time_zero)) w_state_nx = ST_RUN;
        end else if (i_record) begin
          w_store = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_clear) begin
          w_state_nx = ST_RUN;
        end else if (i_browse) begin
          if (r_rec_count != '0) begin
            w_state_nx = ST_BROWSE;
            w_idx_nx   = '0;
          end
        end else if (i_start_stop) begin
          w_state_nx = ST_IDLE;
        end else if (i_record) begin
          w_store = 1'b1;
        end
      end
      ST_BROWSE: begin
        if (i_clear) begin
          w_rec_nx    = '0;
          w_wr_ptr_nx = '0;
          w_idx_nx    = '0;
          w_state_nx  = ST_IDLE;
        end else if (i_browse) begin
          w_idx_nx   = '0;
          w_state_nx = ST_IDLE;
        end else if (i_start_stop) begin
          w_state_nx = ST_BROWSE;
        end else if (i_record) begin
          if (CW'(r_browse_idx) == (r_rec_count - CW'(1))) w_idx_nx = '0;
          else                                              w_idx_nx = r_browse_idx + IW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_cd_done) w_state_nx = ST_IDLE;

    if (w_store) begin
      w_wr_ptr_nx = (r_wr_ptr == IW'(DEPTH - 1)) ? '0 : r_wr_ptr + IW'(1);
      if (r_rec_count != CW'(DEPTH)) w_rec_nx = r_rec_count + CW'(1);
    end
  end

  // Browsed slot walks backwards from the newest write.
  always_comb begin
    w_slot_sum = SW'(r_wr_ptr) + SW'(DEPTH - 1) - SW'(r_browse_idx);
    if (w_slot_sum >= SW'(DEPTH)) w_slot = IW'(w_slot_sum - SW'(DEPTH));
    else                          w_slot = IW'(w_slot_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_time       <= '0;
      r_wr_ptr     <= '0;
      r_rec_count  <= '0;
      r_browse_idx <= '0;
      r_overflow   <= 1'b0;
      r_expired    <= 1'b0;
      r_mode_down  <= 1'b0;
      r_disp       <= '0;
      for (int i = 0; i < DEPTH; i++) r_laps[i] <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_time       <= w_time_nx;
      r_wr_ptr     <= w_wr_ptr_nx;
      r_rec_count  <= w_rec_nx;
      r_browse_idx <= w_idx_nx;
      r_overflow   <= w_ovf_nx;
      r_expired    <= w_exp_nx;
      r_mode_down  <= w_mode_nx;
      r_disp       <= (r_state == ST_BROWSE) ? r_laps[w_slot] : r_time;
      if (w_store) r_laps[r_wr_ptr] <= r_time;
    end
  end

  assign o_disp_min   = r_disp.min;
  assign o_disp_sec   = r_disp.sec;
  assign o_disp_cs    = r_disp.cs;
  assign o_running    = (r_state == ST_RUN);
  assign o_browsing   = (r_state == ST_BROWSE);
  assign o_browse_idx = r_browse_idx;
  assign o_rec_count  = r_rec_count;
  assign o_overflow   = r_overflow;
  assign o_expired    = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_lap_timer_core.sv
// ---------------------------------------------------------------------------
// tb_lap_timer_core : directed, table-driven bench for lap_timer_core
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lap_timer_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ss, rec, br, clr, md;
  logic [5:0] pmin, psec;
  logic       ss2, clr2;

  logic [5:0] o_min, o_sec, o_min2, o_sec2;
  logic [6:0] o_cs, o_cs2;
  logic       o_run, o_brw, o_ovf, o_exp, o_run2, o_brw2, o_ovf2, o_exp2;
  logic [1:0] o_idx, o_idx2;
  logic [2:0] o_rec, o_rec2;

  lap_timer_core #(.CLK_HZ(1000), .TICK_HZ(100), .DEPTH(4), .MAX_MIN(1)) dut (
    .clk(clk), .rst(rst), .i_start_stop(ss), .i_record(rec), .i_browse(br),
    .i_clear(clr), .i_mode_down(md), .i_preset_min(pmin), .i_preset_sec(psec),
    .o_disp_min(o_min), .o_disp_sec(o_sec), .o_disp_cs(o_cs), .o_running(o_run),
    .o_browsing(o_brw), .o_browse_idx(o_idx), .o_rec_count(o_rec),
    .o_overflow(o_ovf), .o_expired(o_exp)
  );

  // Fast-tick instance (DIV=2) keeps the full-range overflow run short.
  lap_timer_core #(.CLK_HZ(1000), .TICK_HZ(500), .DEPTH(4), .MAX_MIN(1)) dut2 (
    .clk(clk), .rst(rst), .i_start_stop(ss2), .i_record(1'b0), .i_browse(1'b0),
    .i_clear(clr2), .i_mode_down(1'b0), .i_preset_min(6'd0), .i_preset_sec(6'd0),
    .o_disp_min(o_min2), .o_disp_sec(o_sec2), .o_disp_cs(o_cs2), .o_running(o_run2),
    .o_browsing(o_brw2), .o_browse_idx(o_idx2), .o_rec_count(o_rec2),
    .o_overflow(o_ovf2), .o_expired(o_exp2)
  );

  typedef struct {
    logic ss, rec, br, clr;
    logic exp_run, exp_brw;
    int   exp_idx, exp_rec, exp_cs;
  } vec_t;

  vec_t vecs [6];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] tv(input int m, input int s, input int c);
    return {13'd0, 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [31:0] disp1();
    return {13'd0, o_min, o_sec, o_cs};
  endfunction

  function automatic logic [31:0] disp2();
    return {13'd0, o_min2, o_sec2, o_cs2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic a_ss, input logic a_rec, input logic a_br, input logic a_clr);
    ss = a_ss; rec = a_rec; br = a_br; clr = a_clr;
    step();
    ss = 1'b0; rec = 1'b0; br = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ss = 0; rec = 0; br = 0; clr = 0; md = 0; pmin = 0; psec = 0;
    ss2 = 0; clr2 = 0;

    vecs[0] = '{ss:0, rec:1, br:0, clr:0, exp_run:0, exp_brw:1, exp_idx:1, exp_rec:4, exp_cs:4};
    vecs[1] = '{ss:0, rec:1, br:0, clr:0, exp_run:0, exp_brw:1, exp_idx:2, exp_rec:4, exp_cs:3};
    vecs[2] = '{ss:0, rec:1, br:0, clr:0, exp_run:0, exp_brw:1, exp_idx:3, exp_rec:4, exp_cs:2};
    vecs[3] = '{ss:0, rec:1, br:0, clr:0, exp_run:0, exp_brw:1, exp_idx:0, exp_rec:4, exp_cs:5};
    vecs[4] = '{ss:1, rec:0, br:0, clr:0, exp_run:0, exp_brw:1, exp_idx:0, exp_rec:4, exp_cs:5};
    vecs[5] = '{ss:0, rec:0, br:1, clr:0, exp_run:0, exp_brw:0, exp_idx:0, exp_rec:4, exp_cs:5};

    wait_cyc(3);
    rst = 1'b0;
    chk("reset_running",  32'(o_run), 0);
    chk("reset_browsing", 32'(o_brw), 0);
    chk("reset_rec",      32'(o_rec), 0);
    chk("reset_overflow", 32'(o_ovf), 0);
    chk("reset_expired",  32'(o_exp), 0);
    chk("reset_disp",     disp1(), 0);

    // Run for 1000 cycles, then pause.
    pulse(1, 0, 0, 0);
    chk("start_running", 32'(o_run), 1);
    wait_cyc(999);
    pulse(1, 0, 0, 0);
    chk("stop_running", 32'(o_run), 0);
    step();
    chk("time_1s", disp1(), tv(0, 1, 0));
    wait_cyc(50);
    chk("time_frozen", disp1(), tv(0, 1, 0));

    // clear + browse + record together: clear alone acts.
    pulse(0, 1, 1, 1);
    chk("prio_rec",  32'(o_rec), 0);
    chk("prio_brw",  32'(o_brw), 0);
    chk("prio_run",  32'(o_run), 0);
    step();
    chk("prio_disp", disp1(), 0);

    // start_stop beats record; then five laps at 1..5 cs.
    pulse(1, 1, 0, 0);
    chk("ss_beats_rec_run", 32'(o_run), 1);
    chk("ss_beats_rec_cnt", 32'(o_rec), 0);
    wait_cyc(14);
    pulse(0, 1, 0, 0);
    chk("lap1_rec", 32'(o_rec), 1);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(9);
      pulse(0, 1, 0, 0);
    end
    chk("laps_saturate", 32'(o_rec), 4);
    pulse(0, 0, 1, 0);
    chk("browse_enter", 32'(o_brw), 1);
    chk("browse_pause", 32'(o_run), 0);
    chk("browse_idx0",  32'(o_idx), 0);
    step();
    chk("browse_newest", disp1(), tv(0, 0, 5));

    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].ss, vecs[i].rec, vecs[i].br, vecs[i].clr);
      chk($sformatf("vec%0d_run", i), 32'(o_run), 32'(vecs[i].exp_run));
      chk($sformatf("vec%0d_brw", i), 32'(o_brw), 32'(vecs[i].exp_brw));
      chk($sformatf("vec%0d_idx", i), 32'(o_idx), 32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_rec", i), 32'(o_rec), 32'(vecs[i].exp_rec));
      step();
      chk($sformatf("vec%0d_disp", i), disp1(), tv(0, 0, vecs[i].exp_cs));
    end

    // clear in browse empties the buffer; browse then has nothing to show.
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    chk("bclear_rec", 32'(o_rec), 0);
    chk("bclear_brw", 32'(o_brw), 0);
    pulse(0, 0, 1, 0);
    chk("browse_empty_ignored", 32'(o_brw), 0);
    for (int k = 0; k < 3; k++) pulse(0, 1, 0, 0);
    chk("idle_laps3", 32'(o_rec), 3);
    pulse(0, 0, 1, 0);
    chk("browse3_enter", 32'(o_brw), 1);
    step();
    chk("browse3_disp", disp1(), tv(0, 0, 5));

    // Reset from BROWSE.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_brw",  32'(o_brw), 0);
    chk("rst_run",  32'(o_run), 0);
    chk("rst_rec",  32'(o_rec), 0);
    chk("rst_idx",  32'(o_idx), 0);
    chk("rst_ovf",  32'(o_ovf), 0);
    chk("rst_exp",  32'(o_exp), 0);
    chk("rst_disp", disp1(), 0);

`ifdef STOPWATCH_COUNTDOWN_EN
    md = 1; pmin = 0; psec = 1;
    pulse(0, 0, 0, 1);
    step();
    chk("cd_load", disp1(), tv(0, 1, 0));
    pulse(1, 0, 0, 0);
    chk("cd_run", 32'(o_run), 1);
    wait_cyc(999);
    chk("cd_not_expired", 32'(o_exp), 0);
    chk("cd_near_zero", disp1(), tv(0, 0, 1));
    step();
    chk("cd_expired", 32'(o_exp), 1);
    chk("cd_stopped", 32'(o_run), 0);
    step();
    chk("cd_zero", disp1(), 0);
    pulse(1, 0, 0, 0);
    chk("cd_ss_ignored", 32'(o_run), 0);
    pmin = 5; psec = 63;
    pulse(0, 0, 0, 1);
    chk("cd_clear_exp", 32'(o_exp), 0);
    step();
    chk("cd_saturate", disp1(), tv(1, 59, 0));
    md = 0;
    pulse(0, 0, 0, 1);
`else
    md = 1; pmin = 0; psec = 1;
    pulse(0, 0, 0, 1);
    step();
    chk("nocd_clear_zero", disp1(), 0);
    pulse(1, 0, 0, 0);
    wait_cyc(999);
    pulse(1, 0, 0, 0);
    step();
    chk("nocd_counts_up", disp1(), tv(0, 1, 0));
    chk("nocd_expired",   32'(o_exp), 0);
    md = 0;
`endif

    // Count-up wrap at 1:59:99 on the fast instance.
    ss2 = 1'b1;
    step();
    ss2 = 1'b0;
    wait_cyc(23999);
    chk("ovf_before", 32'(o_ovf2), 0);
    chk("ovf_max_time", disp2(), tv(1, 59, 99));
    step();
    chk("ovf_set", 32'(o_ovf2), 1);
    step();
    chk("ovf_wrapped", disp2(), 0);
    wait_cyc(10);
    chk("ovf_continues", disp2(), tv(0, 0, 5));
    chk("ovf_sticky", 32'(o_ovf2), 1);
    ss2 = 1'b1;
    step();
    ss2 = 1'b0;
    chk("ovf_stop", 32'(o_run2), 0);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("ovf_cleared", 32'(o_ovf2), 0);
    step();
    chk("ovf_clear_time", disp2(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
